// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage MIPS core control blocks:
// register-zero constant, mult/div tracker state encoding and default latency.
package core_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Default cycles from mult/div issue in EX until HI/LO is written.
   localparam int unsigned MD_LATENCY_DEF = 4;

   // Wide enough for the largest supported latency (31).
   localparam int unsigned MD_CNT_W = 5;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/hazard_unit_md_tracker.sv
// Multi-cycle mult/div occupancy tracker: raises md_busy for MD_LATENCY cycles
// after issue and pulses md_done in the cycle HI/LO is written.
module md_tracker
   import core_pkg::*;
#(
   parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic md_start_ex,
   output logic md_busy,
   output logic md_done
);

   localparam logic [MD_CNT_W-1:0] LAT_LOAD = MD_CNT_W'(MD_LATENCY);

   md_state_t             state_q, state_d;
   logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A start while busy is dropped: ID stalls any mult/div while md_busy is high.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      md_busy = 1'b0;
      md_done = 1'b0;
      case (state_q)
         MD_IDLE: begin
            cnt_d = '0;
            if (md_start_ex) begin
               state_d = MD_BUSY;
               cnt_d   = LAT_LOAD;
            end
         end
         MD_BUSY: begin
            md_busy = 1'b1;
            cnt_d   = cnt_q - MD_CNT_W'(1);
            if (cnt_q == MD_CNT_W'(1)) begin
               md_done = 1'b1;
               state_d = MD_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage MIPS core: load-use and HI/LO stalls,
// taken-branch squash, and a saturating count of stalled cycles.
module hazard_unit
   import core_pkg::*;
#(
   parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs_id,
   input  logic [4:0]       rt_id,
   input  logic             uses_rt_id,
   input  logic             uses_hilo_id,
   input  logic             mem_read_ex,
   input  logic [4:0]       write_reg_addr_ex,
   input  logic             branch_taken_ex,
   input  logic             md_start_ex,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             md_busy,
   output logic             md_done,
   output logic [CNT_W-1:0] stall_count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic load_use;
   logic hilo_wait;
   logic stall;

   md_tracker #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_tracker (
      .clk         (clk),
      .rst_n       (rst_n),
      .md_start_ex (md_start_ex),
      .md_busy     (md_busy),
      .md_done     (md_done)
   );

   assign load_use  = mem_read_ex && (write_reg_addr_ex != REG_ZERO) &&
                      ((write_reg_addr_ex == rs_id) ||
                       (uses_rt_id && (write_reg_addr_ex == rt_id)));
   assign hilo_wait = uses_hilo_id && md_busy;

   // The ID instruction is on the wrong path when a branch is taken, so its hazards are moot.
   assign stall = (load_use || hilo_wait) && !branch_taken_ex;

   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (branch_taken_ex) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         flush_id_ex = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (!pc_write) begin
         stall_count <= sat_inc(stall_count);
      end
   end

endmodule
